// File: rtl/biquad_cascade_filter_pkg.sv
// Shared types and arithmetic helpers for the time-multiplexed biquad cascade.
// The round and saturate helpers work on 64-bit values so any width set can use them.
package biquad_pkg;

  typedef enum logic [1:0] {IDLE, MAC, WB, OUT} state_t;

  localparam logic [2:0] TAP_B0 = 3'd0;
  localparam logic [2:0] TAP_B1 = 3'd1;
  localparam logic [2:0] TAP_B2 = 3'd2;
  localparam logic [2:0] TAP_A1 = 3'd3;
  localparam logic [2:0] TAP_A2 = 3'd4;
  localparam int N_TAPS = 5;

  function automatic int coef_addr(input int section, input int tap);
    return section * N_TAPS + tap;
  endfunction

  // Round half up, then drop the fractional bits.
  function automatic logic signed [63:0] round_shr(input logic signed [63:0] v, input int frac);
    return (v + (64'sd1 <<< (frac - 1))) >>> frac;
  endfunction

  function automatic logic signed [63:0] saturate(input logic signed [63:0] v, input int width);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (width - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (width - 1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/biquad_cascade_filter_if.sv
// Sample stream, control and coefficient bus of the biquad cascade.
// master = the side feeding samples and coefficients, slave = the filter.
interface biquad_cascade_filter_if #(
  parameter int DATA_W = 16,
  parameter int COEF_W = 18,
  parameter int ADDR_W = 4
);
  logic                     clear_i;
  logic signed [DATA_W-1:0] in_data_i;
  logic                     in_valid_i;
  logic                     in_ready_o;
  logic signed [DATA_W-1:0] out_data_o;
  logic                     out_valid_o;
  logic                     out_ready_i;
  logic                     coef_we_i;
  logic [ADDR_W-1:0]        coef_addr_i;
  logic signed [COEF_W-1:0] coef_wdata_i;
  logic                     coef_err_o;
  logic                     sat_o;
  logic                     busy_o;

  modport master (
    output clear_i, in_data_i, in_valid_i, out_ready_i, coef_we_i, coef_addr_i, coef_wdata_i,
    input  in_ready_o, out_data_o, out_valid_o, coef_err_o, sat_o, busy_o
  );

  modport slave (
    input  clear_i, in_data_i, in_valid_i, out_ready_i, coef_we_i, coef_addr_i, coef_wdata_i,
    output in_ready_o, out_data_o, out_valid_o, coef_err_o, sat_o, busy_o
  );
endinterface

// File: rtl/biquad_cascade_filter_mac.sv
// Shared multiply-accumulate with add/subtract select and a round+saturate output stage.
// One product per enabled cycle; y/y_sat are combinational from the accumulator.
module biquad_mac
  import biquad_pkg::*;
#(
  parameter int DATA_W    = 16,
  parameter int COEF_W    = 18,
  parameter int COEF_FRAC = 14,
  parameter int ACC_W     = DATA_W + COEF_W + 4
) (
  input  logic                     clk_i,
  input  logic                     reset_ni,
  input  logic                     acc_clr,
  input  logic                     acc_en,
  input  logic                     acc_sub,
  input  logic signed [COEF_W-1:0] coef,
  input  logic signed [DATA_W-1:0] operand,
  output logic signed [DATA_W-1:0] y,
  output logic                     y_sat
);
  localparam int PROD_W = DATA_W + COEF_W;

  logic signed [PROD_W-1:0] prod;
  logic signed [ACC_W-1:0]  prod_ext;
  logic signed [ACC_W-1:0]  acc_q;
  logic signed [63:0]       rounded;
  logic signed [63:0]       clipped;

  assign prod     = coef * operand;
  assign prod_ext = {{(ACC_W - PROD_W){prod[PROD_W-1]}}, prod};

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      acc_q <= '0;
    end else if (acc_clr) begin
      acc_q <= '0;
    end else if (acc_en) begin
      acc_q <= acc_sub ? acc_q - prod_ext : acc_q + prod_ext;
    end
  end

  assign rounded = round_shr({{(64 - ACC_W){acc_q[ACC_W-1]}}, acc_q}, COEF_FRAC);
  assign clipped = saturate(rounded, DATA_W);
  assign y_sat   = (clipped != rounded);
  assign y       = clipped[DATA_W-1:0];

endmodule

// File: rtl/biquad_cascade_filter.sv
// Cascade of N Direct Form I biquads sharing one MAC; 6 cycles per section, output after edge 6*N.
// No skid buffer: in_ready only in IDLE; result held in OUT until out_ready.
module biquad_cascade_filter
  import biquad_pkg::*;
#(
  parameter int DATA_W     = 16,
  parameter int COEF_W     = 18,
  parameter int COEF_FRAC  = 14,
  parameter int N_SECTIONS = 2,
  parameter int ACC_W      = DATA_W + COEF_W + 4
) (
  input logic                    clk_i,
  input logic                    reset_ni,
  biquad_cascade_filter_if.slave bus
);
  localparam int N_COEF = N_TAPS * N_SECTIONS;
  localparam int ADDR_W = $clog2(N_COEF);
  localparam int SEC_W  = (N_SECTIONS > 1) ? $clog2(N_SECTIONS) : 1;
  localparam logic signed [COEF_W-1:0] COEF_ONE = COEF_W'(1 << COEF_FRAC);

  state_t state_q, state_d;

  logic [SEC_W-1:0]         sec_q;
  logic [2:0]               tap_q;
  logic signed [DATA_W-1:0] x_q;
  logic signed [DATA_W-1:0] out_data_q;
  logic signed [DATA_W-1:0] x1_q [N_SECTIONS];
  logic signed [DATA_W-1:0] x2_q [N_SECTIONS];
  logic signed [DATA_W-1:0] y1_q [N_SECTIONS];
  logic signed [DATA_W-1:0] y2_q [N_SECTIONS];
  logic signed [COEF_W-1:0] coef_q [N_COEF];
  logic                     sat_q;
  logic                     coef_err_q;

  logic                     clear;
  logic                     in_hs;
  logic                     last_sec;
  logic                     last_tap;
  logic                     coef_ok;
  logic [ADDR_W-1:0]        cidx;
  logic signed [DATA_W-1:0] operand;
  logic signed [DATA_W-1:0] y;
  logic                     y_sat;

  assign clear    = bus.clear_i;
  assign in_hs    = bus.in_valid_i && bus.in_ready_o;
  assign last_sec = (int'(sec_q) == N_SECTIONS - 1);
  assign last_tap = (tap_q == TAP_A2);
  assign coef_ok  = bus.coef_we_i && (state_q == IDLE) && (int'(bus.coef_addr_i) < N_COEF);
  assign cidx     = ADDR_W'(coef_addr(int'(sec_q), int'(tap_q)));

  always_comb begin
    operand = x_q;
    case (tap_q)
      TAP_B0:  operand = x_q;
      TAP_B1:  operand = x1_q[sec_q];
      TAP_B2:  operand = x2_q[sec_q];
      TAP_A1:  operand = y1_q[sec_q];
      TAP_A2:  operand = y2_q[sec_q];
      default: operand = x_q;
    endcase
  end

  biquad_mac #(
    .DATA_W(DATA_W), .COEF_W(COEF_W), .COEF_FRAC(COEF_FRAC), .ACC_W(ACC_W)
  ) u_mac (
    .clk_i   (clk_i),
    .reset_ni(reset_ni),
    .acc_clr (clear || in_hs || (state_q == WB)),
    .acc_en  ((state_q == MAC) && !clear),
    .acc_sub (tap_q >= TAP_A1),
    .coef    (coef_q[cidx]),
    .operand (operand),
    .y       (y),
    .y_sat   (y_sat)
  );

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) state_q <= IDLE;
    else           state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (in_hs) state_d = MAC;
        MAC:     if (last_tap) state_d = WB;
        WB:      state_d = last_sec ? OUT : MAC;
        OUT:     if (bus.out_ready_i) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    bus.in_ready_o  = 1'b0;
    bus.out_valid_o = 1'b0;
    bus.busy_o      = 1'b1;
    case (state_q)
      IDLE: begin
        bus.in_ready_o = !clear;
        bus.busy_o     = 1'b0;
      end
      OUT:     bus.out_valid_o = 1'b1;
      default: ;
    endcase
  end

  assign bus.out_data_o = out_data_q;
  assign bus.sat_o      = sat_q;
  assign bus.coef_err_o = coef_err_q;

  // Coefficients survive clear_i; only reset restores passthrough.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      sec_q      <= '0;
      tap_q      <= '0;
      x_q        <= '0;
      out_data_q <= '0;
      sat_q      <= 1'b0;
      coef_err_q <= 1'b0;
      for (int i = 0; i < N_SECTIONS; i++) begin
        x1_q[i] <= '0;
        x2_q[i] <= '0;
        y1_q[i] <= '0;
        y2_q[i] <= '0;
      end
      for (int i = 0; i < N_COEF; i++) begin
        coef_q[i] <= (i % N_TAPS == 0) ? COEF_ONE : '0;
      end
    end else begin
      coef_err_q <= bus.coef_we_i && !coef_ok;
      if (coef_ok) coef_q[bus.coef_addr_i] <= bus.coef_wdata_i;

      if (clear) begin
        sec_q <= '0;
        tap_q <= '0;
        x_q   <= '0;
        sat_q <= 1'b0;
        for (int i = 0; i < N_SECTIONS; i++) begin
          x1_q[i] <= '0;
          x2_q[i] <= '0;
          y1_q[i] <= '0;
          y2_q[i] <= '0;
        end
      end else begin
        case (state_q)
          IDLE: if (in_hs) begin
            x_q   <= bus.in_data_i;
            sec_q <= '0;
            tap_q <= '0;
          end
          MAC: tap_q <= tap_q + 3'd1;
          WB: begin
            x2_q[sec_q] <= x1_q[sec_q];
            x1_q[sec_q] <= x_q;
            y2_q[sec_q] <= y1_q[sec_q];
            y1_q[sec_q] <= y;
            tap_q       <= '0;
            if (y_sat) sat_q <= 1'b1;
            if (last_sec) begin
              out_data_q <= y;
            end else begin
              x_q   <= y;
              sec_q <= sec_q + 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule
